// File: rtl/mac_cluster_cfg_loader.sv
// mac_cluster_cfg_loader: serial loader that builds the mac_cluster cfg word from chunks and pulses cset
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready chunk stream, LSB chunk first;
// abort drops a partial load; run_en host run enable; cfg/cset/en_out drive the cluster; busy = not idle.
module mac_cluster_cfg_loader #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int IN_WIDTH       = 8,
    parameter int SETTLE_CYCLES  = 2,
    localparam int CFG_WIDTH     = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH,
    localparam int NUM_CHUNKS    = (CFG_WIDTH + IN_WIDTH - 1) / IN_WIDTH,
    localparam int CW            = $clog2(NUM_CHUNKS + 1),
    localparam int SW            = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 abort,
    input  logic                 run_en,
    output logic [CFG_WIDTH-1:0] cfg,
    output logic                 cset,
    output logic                 en_out,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, SETTLE} state_t;
    state_t               state, state_n;
    logic [CW-1:0]        chunk_cnt, chunk_cnt_n, idx;
    logic [SW-1:0]        settle_cnt, settle_cnt_n;
    logic [CFG_WIDTH-1:0] cfg_n;
    logic                 accept;
    always_comb begin
        state_n      = state;
        chunk_cnt_n  = chunk_cnt;
        settle_cnt_n = settle_cnt;
        cfg_n        = cfg;
        in_ready     = (state == IDLE || state == LOAD) && !abort && !rst;
        en_out       = state == IDLE && run_en && !rst;
        accept       = in_valid && in_ready;
        idx          = state == IDLE ? '0 : chunk_cnt;
        // bits past CFG_WIDTH-1 in the last chunk simply have no destination
        for (int i = 0; i < CFG_WIDTH; i++)
            if (accept && i / IN_WIDTH == int'(idx)) cfg_n[i] = in_data[i % IN_WIDTH];
        case (state)
            IDLE: begin
                chunk_cnt_n = accept ? CW'(1) : '0;
                if (accept) state_n = NUM_CHUNKS == 1 ? COMMIT : LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_n     = IDLE;
                    chunk_cnt_n = '0;
                end else if (accept) begin
                    chunk_cnt_n = chunk_cnt + CW'(1);
                    if (int'(chunk_cnt) == NUM_CHUNKS - 1) state_n = COMMIT;
                end
            end
            COMMIT: begin
                state_n      = SETTLE;
                chunk_cnt_n  = '0;
                settle_cnt_n = SW'(SETTLE_CYCLES - 1);
            end
            default: begin
                if (settle_cnt == '0) state_n = IDLE;
                else settle_cnt_n = settle_cnt - SW'(1);
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            chunk_cnt  <= '0;
            settle_cnt <= '0;
            cfg        <= '0;
            cset       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            chunk_cnt  <= chunk_cnt_n;
            settle_cnt <= settle_cnt_n;
            cfg        <= cfg_n;
            cset       <= state_n == COMMIT;
            busy       <= state_n != IDLE;
        end
    end
endmodule
